// File: rtl/vicuna_launch_ctrl.sv
// TL-UL register-mapped run controller for Vicuna worker cores: per-core boot
// address, reset/fetch-enable sequencing, done tracking and a level irq.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module vicuna_launch_ctrl
    import tlul_pkg::*;
#(
    parameter int unsigned NumCores        = 2,
    parameter int unsigned RstCycles       = 8,
    parameter logic [31:0] BootAddrDefault = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  tl_h2d_t                tl_i,
    output tl_d2h_t                tl_o,
    output logic [NumCores-1:0]    core_rst_no,
    output logic [NumCores-1:0]    core_fetch_en_o,
    output logic [NumCores*32-1:0] core_boot_addr_o,
    input  logic [NumCores-1:0]    core_done_i,
    output logic                   irq_o
);
    localparam int CntW = (RstCycles > 1) ? $clog2(RstCycles) : 1;

    typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} core_st_e;

    logic                      rsp_pending_q, rsp_err_q;
    logic [2:0]                rsp_op_q;
    logic [1:0]                rsp_size_q;
    logic [7:0]                rsp_source_q;
    logic [31:0]               rsp_data_q;
    logic [NumCores-1:0]       done_q, done_d, irq_en_q, irq_en_d;
    logic [NumCores-1:0][31:0] boot_q;
    logic                      irq_q;

    logic                a_ready, accept, is_get, is_put, mapped, err, wr;
    logic [5:0]          widx;
    logic                hit_start, hit_abort, hit_status, hit_clr, hit_irqen, hit_boot;
    logic [NumCores-1:0] start_w, abort_w, clr_w, boot_we;
    logic [NumCores-1:0] busy, run, done_set, boot_ok;
    logic [31:0]         rdata;

    // Only the low byte of the address is decoded; the crossbar selects this window.
    assign widx       = tl_i.a_address[7:2];
    assign hit_start  = (widx == 6'd0);
    assign hit_abort  = (widx == 6'd1);
    assign hit_status = (widx == 6'd2);
    assign hit_clr    = (widx == 6'd3);
    assign hit_irqen  = (widx == 6'd4);
    assign hit_boot   = (widx[5:3] == 3'b001) && (32'(widx[2:0]) < NumCores);
    assign mapped     = hit_start | hit_abort | hit_status | hit_clr | hit_irqen | hit_boot;

    assign is_get  = (tl_i.a_opcode == Get);
    assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign err     = !(mapped && (is_get || is_put));
    assign a_ready = !rsp_pending_q || tl_i.d_ready;
    assign accept  = tl_i.a_valid && a_ready;
    assign wr      = accept && is_put && !err;

    assign start_w = (wr && hit_start) ? tl_i.a_data[NumCores-1:0] : '0;
    assign abort_w = (wr && hit_abort) ? tl_i.a_data[NumCores-1:0] : '0;
    assign clr_w   = (wr && hit_clr)   ? tl_i.a_data[NumCores-1:0] : '0;

    always_comb begin
        boot_we = '0;
        for (int i = 0; i < NumCores; i++)
            boot_we[i] = wr && hit_boot && (widx[2:0] == 3'(i)) && boot_ok[i];
    end

    always_comb begin
        rdata = '0;
        if (is_get && !err) begin
            if (hit_status) begin
                rdata[NumCores-1:0] = busy;
                rdata[8+:NumCores]  = done_q;
            end else if (hit_irqen) begin
                rdata[NumCores-1:0] = irq_en_q;
            end else if (hit_boot) begin
                for (int i = 0; i < NumCores; i++)
                    if (widx[2:0] == 3'(i)) rdata = boot_q[i];
            end
        end
    end

    // A done pulse in the same cycle as DONE_CLR must survive, hence set after clear.
    assign done_d   = (done_q & ~clr_w) | done_set;
    assign irq_en_d = (wr && hit_irqen) ? tl_i.a_data[NumCores-1:0] : irq_en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            boot_q   <= {NumCores{BootAddrDefault}};
        end else begin
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(done_q & irq_en_q);
            for (int i = 0; i < NumCores; i++)
                if (boot_we[i]) boot_q[i] <= tl_i.a_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_pending_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_op_q      <= AccessAck;
            rsp_size_q    <= '0;
            rsp_source_q  <= '0;
            rsp_data_q    <= '0;
        end else if (accept) begin
            rsp_pending_q <= 1'b1;
            rsp_err_q     <= err;
            rsp_op_q      <= is_get ? AccessAckData : AccessAck;
            rsp_size_q    <= tl_i.a_size;
            rsp_source_q  <= tl_i.a_source;
            rsp_data_q    <= rdata;
        end else if (tl_i.d_ready) begin
            rsp_pending_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NumCores; i++) begin : g_core
        core_st_e        st_q, st_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            run_q, set_l;

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            set_l = 1'b0;
            case (st_q)
                StIdle, StDone: if (start_w[i]) begin
                    st_d  = StRst;
                    cnt_d = CntW'(RstCycles - 1);
                end
                StRst: begin
                    if (cnt_q == '0) st_d = StRun;
                    else             cnt_d = cnt_q - 1'b1;
                end
                StRun: if (core_done_i[i]) begin
                    st_d  = StDone;
                    set_l = 1'b1;
                end
                default: st_d = StIdle;
            endcase
            if (abort_w[i]) begin
                st_d  = StIdle;
                set_l = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                st_q  <= StIdle;
                cnt_q <= '0;
                run_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                run_q <= (st_d == StRun);
            end
        end

        assign run[i]      = run_q;
        assign done_set[i] = set_l;
        assign busy[i]     = (st_q == StRst) || (st_q == StRun);
        assign boot_ok[i]  = (st_q == StIdle) || (st_q == StDone);
    end

    assign core_rst_no      = run;
    assign core_fetch_en_o  = run;
    assign core_boot_addr_o = boot_q;
    assign irq_o            = irq_q;

    assign tl_o.d_valid  = rsp_pending_q;
    assign tl_o.d_opcode = rsp_op_q;
    assign tl_o.d_param  = 3'b0;
    assign tl_o.d_size   = rsp_size_q;
    assign tl_o.d_source = rsp_source_q;
    assign tl_o.d_sink   = 1'b0;
    assign tl_o.d_data   = rsp_data_q;
    assign tl_o.d_error  = rsp_err_q;
    assign tl_o.a_ready  = a_ready;

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[31:8], tl_i.a_address[1:0]};
endmodule

// File: tb/tb_vicuna_launch_ctrl.sv
// Directed bench for vicuna_launch_ctrl: register access, core sequencing,
// done/irq handling and TL-UL backpressure with immediate-assertion checks.
module tb_vicuna_launch_ctrl;
    import tlul_pkg::*;
    localparam int NC = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    tl_h2d_t      tl_i;
    tl_d2h_t      tl_o;
    logic [NC-1:0] rst_no, fen, done_i;
    logic [NC*32-1:0] ba;
    logic         irq;

    int nvec = 0;
    int nerr = 0;

    vicuna_launch_ctrl #(.NumCores(NC), .RstCycles(8), .BootAddrDefault(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
        .core_rst_no(rst_no), .core_fetch_en_o(fen), .core_boot_addr_o(ba),
        .core_done_i(done_i), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [NC-1:0] dpulse, output logic [31:0] rdata, output logic rerr);
        int n = 0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = 4'hf;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = 8'h3c;
        done_i         = dpulse;
        while (!tl_o.a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("a_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
        done_i       = '0;
        @(negedge clk);
        chk("d_valid", tl_o.d_valid, 1);
        chk("d_opcode", tl_o.d_opcode, (op == Get) ? AccessAckData : AccessAck);
        chk("d_source", tl_o.d_source, 8'h3c);
        rdata = tl_o.d_data;
        rerr  = tl_o.d_error;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        e;
        xfer(PutFullData, addr, data, '0, rd, e);
        chk($sformatf("put_err_%0h", addr), e, 0);
    endtask

    task automatic get_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        xfer(Get, addr, 32'h0, '0, rd, e);
        chk({tag, "_err"}, e, 0);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        done_i = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rst_no", rst_no, 0);
        chk("rst_fetch_en", fen, 0);
        chk("rst_irq", irq, 0);
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_a_ready", tl_o.a_ready, 1);
        chk("rst_boot_addr", ba, 0);
        rst_n = 1'b1;
        @(negedge clk);
        get_chk("boot0_reset", 32'h20, 32'h0);
        get_chk("start_reads_zero", 32'h00, 32'h0);

        // Core1 boot: 8 cycles of reset, then run
        put(32'h24, 32'h0010_0000);
        put(32'h00, 32'h2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("c1_rst_low_%0d", i), rst_no[1], 0);
            @(negedge clk);
        end
        chk("c1_rst_high", rst_no[1], 1);
        chk("c1_fetch_en", fen[1], 1);
        chk("c1_boot_addr", ba[63:32], 32'h0010_0000);
        chk("c0_stays_idle", rst_no[0], 0);
        get_chk("status_c1_busy", 32'h08, 32'h002);
        put(32'h04, 32'h2);
        get_chk("status_c1_aborted", 32'h08, 32'h0);

        // Core0 done with irq
        put(32'h10, 32'h1);
        get_chk("irq_en_rb", 32'h10, 32'h1);
        done_i = 2'b01;                         // ignored outside RUN
        @(negedge clk);
        done_i = '0;
        get_chk("done_ignored_idle", 32'h08, 32'h0);
        put(32'h00, 32'h1);
        repeat (8) @(negedge clk);
        chk("c0_running", fen[0], 1);
        done_i = 2'b01;
        @(posedge clk);
        #1 done_i = '0;
        @(negedge clk);
        chk("c0_done_fetch_off", fen[0], 0);
        chk("c0_done_rst_low", rst_no[0], 0);
        chk("irq_lag", irq, 0);
        @(negedge clk);
        chk("irq_set", irq, 1);
        get_chk("status_done", 32'h08, 32'h100);
        put(32'h0C, 32'h1);
        @(negedge clk);
        chk("irq_cleared", irq, 0);
        get_chk("status_cleared", 32'h08, 32'h0);

        // Boot address locked while running; abort paths
        put(32'h00, 32'h1);
        repeat (8) @(negedge clk);
        chk("c0_run2", fen[0], 1);
        put(32'h20, 32'hDEAD_0000);
        get_chk("boot0_locked", 32'h20, 32'h0);
        chk("boot0_out_locked", ba[31:0], 32'h0);
        put(32'h04, 32'h1);
        chk("abort_fetch_off", fen[0], 0);
        get_chk("status_after_abort", 32'h08, 32'h0);
        put(32'h00, 32'h1);
        put(32'h04, 32'h1);
        get_chk("status_start_abort", 32'h08, 32'h0);
        chk("start_abort_rst", rst_no[0], 0);
        put(32'h20, 32'h1234_5678);
        get_chk("boot0_idle_write", 32'h20, 32'h1234_5678);
        chk("boot0_out", ba[31:0], 32'h1234_5678);

        // done pulse in same cycle as DONE_CLR: set wins
        put(32'h00, 32'h1);
        repeat (8) @(negedge clk);
        xfer(PutFullData, 32'h0C, 32'h1, 2'b01, rd, e);
        chk("clr_race_err", e, 0);
        get_chk("status_set_wins", 32'h08, 32'h100);
        chk("irq_set_wins", irq, 1);

        // Error responses leave state alone
        xfer(3'h2, 32'h08, 32'h0, '0, rd, e);
        chk("bad_opcode_err", e, 1);
        chk("bad_opcode_data", rd, 0);
        xfer(PutFullData, 32'h14, 32'hFFFF_FFFF, '0, rd, e);
        chk("unmapped_put_err", e, 1);
        xfer(PutFullData, 32'h28, 32'hFFFF_FFFF, '0, rd, e);
        chk("boot_oob_err", e, 1);
        get_chk("status_after_errs", 32'h08, 32'h100);

        // Unmapped Get with d_ready held low
        @(negedge clk);
        tl_i.d_ready   = 1'b0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = Get;
        tl_i.a_address = 32'h40;
        chk("bp_a_ready_idle", tl_o.a_ready, 1);
        @(posedge clk);
        #1 tl_i.a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_d_valid_%0d", i), tl_o.d_valid, 1);
            chk($sformatf("bp_d_error_%0d", i), tl_o.d_error, 1);
            chk($sformatf("bp_d_data_%0d", i), tl_o.d_data, 0);
            chk($sformatf("bp_a_ready_%0d", i), tl_o.a_ready, 0);
        end
        tl_i.d_ready = 1'b1;
        #1 chk("bp_a_ready_release", tl_o.a_ready, 1);
        @(negedge clk);
        chk("bp_d_valid_drop", tl_o.d_valid, 0);

        // Async reset mid-run
        put(32'h00, 32'h2);
        repeat (8) @(negedge clk);
        chk("c1_run_pre_reset", rst_no[1], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_no", rst_no, 0);
        chk("async_fetch_en", fen, 0);
        chk("async_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        get_chk("status_post_reset", 32'h08, 32'h0);
        get_chk("boot0_post_reset", 32'h20, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
